gate_exerciser: RTL and testbench
=================================

Name: gate_exerciser

Overview:
- Self-checking stimulus/response engine for the two-input gate bank.
- Drives the bank's inputs a and b through all four vectors, with a=MSB, in order 00, 01, 10, 11.
- Samples the bank's seven outputs after a programmable settle time and compares them with expected values.
- Reports pass/fail, a per-gate error mask, a failing-vector count and the first failing vector.
- Sits on the opposite side of the gate bank's interface, for on-board and bench self-test.

Parameters:
- SETTLE_CYCLES, default 2: cycles between applying a vector and sampling res. Legal range 1..255; values outside it are an elaboration error.
- CNT_W, default $clog2(SETTLE_CYCLES+1): localparam, width of the settle counter. Not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle run request; honoured only in IDLE.
- res  input  7  gate bank outputs. Bit order: [0]=and, [1]=or, [2]=not, [3]=xor, [4]=nand, [5]=nor, [6]=xnor.
- a  output  1  stimulus to gate bank, registered.
- b  output  1  stimulus to gate bank, registered.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 if no mismatch in last run; valid from done until next start.
- err_mask  output  7  sticky per-gate mismatch flags for the current/last run.
- fail_count  output  3  number of vectors with at least one mismatch, 0..4.
- first_fail_vec  output  2  {a,b} of first failing vector; 00 when pass=1.

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_mask=0, fail_count=0, first_fail_vec=0, settle counter=0, vector index=0. Reset wins over every other event, including mid-run; the run is abandoned with no done pulse.
- Expected values for vector {a,b}:
  - and=a&b, or=a|b, not=~a, xor=a^b.
  - nand=~(a&b), nor=~(a|b), xnor=~(a^b).
  - not is defined on input a only; b is don't-care for that bit.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1 at edge:
  - vec<=0; {a,b}<=00; cnt<=SETTLE_CYCLES-1.
  - err_mask<=0; fail_count<=0; first_fail_vec<=0; pass<=0.
  - state<=SETTLE.
- IDLE, start=0: hold. All result outputs keep the last run's values.
- SETTLE: res is ignored in this state; glitches here must not affect results. If cnt==0, state<=CHECK; else cnt<=cnt-1. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK: lasts one cycle. Let m = res XOR expected({a,b}).
  - err_mask<=err_mask|m.
  - If m!=0: fail_count<=fail_count+1, and if fail_count==0 also first_fail_vec<=vec.
  - If vec==3: state<=DONE.
  - Else: vec<=vec+1; {a,b}<=vec+1; cnt<=SETTLE_CYCLES-1; state<=SETTLE.
- DONE: lasts one cycle.
  - done=1 (combinational decode of state, one cycle wide).
  - pass = (err_mask==0), registered on the CHECK->DONE edge from the final mask so it is valid during the done cycle.
  - state<=IDLE. a and b hold 11 until the next start.
- Latency: done is high in the cycle that begins 4*(SETTLE_CYCLES+1) rising edges after the edge that sampled start. With the default SETTLE_CYCLES=2 this is 12 edges.
- start while busy or in DONE: ignored. No queuing, no restart.
- fail_count saturates naturally at 4; the 3-bit width covers it.
- No combinational path from res to any output.

Decomposition:
- Package gate_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, DONE);
  - res bit-index constants (IDX_AND=0 .. IDX_XNOR=6);
  - function gate_expect(a,b) returning the 7-bit expected vector.
- No sub-module. The settle counter and vector index are inline; gate_expect replaces any ROM.
- The bench reuses gate_pkg::gate_expect for its golden model.

Test Plan:
- Correct gate bank, SETTLE_CYCLES=2, start pulse -> vectors 00,01,10,11 seen on a,b; done at edge 12; pass=1; err_mask=0000000; fail_count=0; first_fail_vec=00.
- res[2] driven from b instead of ~a -> vectors 00 and 11 mismatch; pass=0; err_mask=0000100; fail_count=2; first_fail_vec=00.
- res[0] stuck at 1 -> vectors 00,01,10 fail; err_mask=0000001; fail_count=3; first_fail_vec=00.
- res forced to wrong values during every SETTLE cycle, correct in CHECK -> pass=1. Second start pulse while busy -> ignored; exactly one done pulse.
- rst asserted in the 2nd SETTLE cycle of vector 10 -> next cycle a=b=0, busy=0, all flags 0, no done. A fresh start then gives a full pass run.
- Back-to-back runs, failing then correct bank -> second start clears err_mask/fail_count; second done gives pass=1 with SETTLE_CYCLES=1 (done at edge 8).

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and golden model for the two-input gate bank and its exerciser.
package gate_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int RES_W    = 7;
   localparam int IDX_AND  = 0;
   localparam int IDX_OR   = 1;
   localparam int IDX_NOT  = 2;
   localparam int IDX_XNOR = 6;
   localparam int IDX_XOR  = 3;
   localparam int IDX_NAND = 4;
   localparam int IDX_NOR  = 5;

   // The not gate looks at a only; b is a don't-care for that bit.
   function automatic logic [RES_W-1:0] gate_expect(input logic a, input logic b);
      logic [RES_W-1:0] e;
      e           = '0;
      e[IDX_AND]  = a & b;
      e[IDX_OR]   = a | b;
      e[IDX_NOT]  = ~a;
      e[IDX_XOR]  = a ^ b;
      e[IDX_NAND] = ~(a & b);
      e[IDX_NOR]  = ~(a | b);
      e[IDX_XNOR] = ~(a ^ b);
      return e;
   endfunction

endpackage

// File: rtl/gate_exerciser.sv
// Stimulus/response self-test engine: walks {a,b} through 00..11, samples the
// gate bank after a settle delay and accumulates per-gate mismatch results.
module gate_exerciser #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] res,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] err_mask,
   output logic [2:0] fail_count,
   output logic [1:0] first_fail_vec
);
   import gate_pkg::*;

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("gate_exerciser: SETTLE_CYCLES must be in 1..255");
   end

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       vec;
   logic [6:0]       mism;

   // Only consumed in CHECK, so settle-time glitches on res never reach state.
   assign mism = res ^ gate_expect(a, b);

   // NOTE: state is updated with <= so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: next_state gets a default first so no path can infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = SETTLE;
         SETTLE:  if (cnt == '0) next_state = CHECK;
         CHECK:   next_state = (vec == 2'd3) ? DONE : SETTLE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a              <= 1'b0;
         b              <= 1'b0;
         vec            <= '0;
         cnt            <= '0;
         pass           <= 1'b0;
         err_mask       <= '0;
         fail_count     <= '0;
         first_fail_vec <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  vec            <= '0;
                  a              <= 1'b0;
                  b              <= 1'b0;
                  cnt            <= CNT_LOAD;
                  pass           <= 1'b0;
                  err_mask       <= '0;
                  fail_count     <= '0;
                  first_fail_vec <= '0;
               end
            end
            SETTLE: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            CHECK: begin
               err_mask <= err_mask | mism;
               if (mism != '0) begin
                  fail_count <= fail_count + 3'd1;
                  if (fail_count == '0) first_fail_vec <= vec;
               end
               if (vec == 2'd3) begin
                  // Final mask is formed here so pass is valid during done.
                  pass <= ((err_mask | mism) == '0);
               end else begin
                  vec    <= vec + 2'd1;
                  {a, b} <= vec + 2'd1;
                  cnt    <= CNT_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == SETTLE) || (state == CHECK);
   assign done = (state == DONE);

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: a modelled gate bank with injectable
// faults drives res; expected run results are queued at start, checked at done.
module tb_gate_exerciser;
   import gate_pkg::*;

   typedef struct {
      logic       pass;
      logic [6:0] mask;
      logic [2:0] fc;
      logic [1:0] ffv;
   } result_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start2 = 1'b0, start1 = 1'b0;
   logic [6:0] res2, res1;
   logic       a2, b2, busy2, done2, pass2;
   logic       a1, b1, busy1, done1, pass1;
   logic [6:0] err2, err1;
   logic [2:0] fc2, fc1;
   logic [1:0] ffv2, ffv1;

   int fault  = 0;
   bit glitch = 1'b0;
   int sel    = 0;

   int n_checks = 0;
   int n_fail   = 0;

   result_t    exp_q[$];
   logic [1:0] vec_q[$];

   gate_exerciser #(.SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .res(res2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .pass(pass2), .err_mask(err2),
      .fail_count(fc2), .first_fail_vec(ffv2)
   );

   gate_exerciser #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .res(res1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_mask(err1),
      .fail_count(fc1), .first_fail_vec(ffv1)
   );

   // Gate bank model: 1 = not gate wired to b, 2 = and gate stuck at 1.
   function automatic logic [6:0] bank(input logic x, input logic y, input int f);
      logic [6:0] r;
      r = gate_expect(x, y);
      if (f == 1)      r[IDX_NOT] = y;
      else if (f == 2) r[IDX_AND] = 1'b1;
      return r;
   endfunction

   always_comb res2 = glitch ? ~bank(a2, b2, fault) : bank(a2, b2, fault);
   always_comb res1 = bank(a1, b1, fault);

   logic       o_a, o_b, o_busy, o_done, o_pass;
   logic [6:0] o_err;
   logic [2:0] o_fc;
   logic [1:0] o_ffv;
   always_comb begin
      o_a    = (sel == 1) ? a1    : a2;
      o_b    = (sel == 1) ? b1    : b2;
      o_busy = (sel == 1) ? busy1 : busy2;
      o_done = (sel == 1) ? done1 : done2;
      o_pass = (sel == 1) ? pass1 : pass2;
      o_err  = (sel == 1) ? err1  : err2;
      o_fc   = (sel == 1) ? fc1   : fc2;
      o_ffv  = (sel == 1) ? ffv1  : ffv2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel == 1) start1 = v;
      else          start2 = v;
   endtask

   // Vector monitor: each new {a,b} seen while busy is checked against the queue.
   logic       prev_busy = 1'b0;
   logic [1:0] prev_ab   = 2'b00;
   always @(negedge clk) begin
      if (o_busy === 1'b1 && (!prev_busy || {o_a, o_b} != prev_ab)) begin
         if (vec_q.size() == 0) check("vec_extra", vec_q.size(), 1);
         else                   check("vec_order", {o_a, o_b}, vec_q.pop_front());
      end
      prev_busy <= (o_busy === 1'b1);
      prev_ab   <= {o_a, o_b};
   end

   task automatic check_result(input string tag);
      result_t r;
      if (exp_q.size() == 0) begin
         check({tag, "_unexpected_done"}, exp_q.size(), 1);
      end else begin
         r = exp_q.pop_front();
         check({tag, "_pass"},  o_pass, r.pass);
         check({tag, "_mask"},  o_err,  r.mask);
         check({tag, "_fc"},    o_fc,   r.fc);
         check({tag, "_ffv"},   o_ffv,  r.ffv);
      end
   endtask

   task automatic run(input string tag, input int s, input int f,
                      input bit glitch_mode, input bit extra_start);
      result_t    r;
      logic [6:0] m;
      logic [1:0] v;
      int         exp_edge, first_done, n_done;
      r = '{pass: 1'b0, mask: '0, fc: '0, ffv: '0};
      for (int i = 0; i < 4; i++) begin
         v = 2'(i);
         m = bank(v[1], v[0], f) ^ gate_expect(v[1], v[0]);
         r.mask |= m;
         if (m != '0) begin
            if (r.fc == 0) r.ffv = v;
            r.fc++;
         end
         vec_q.push_back(v);
      end
      r.pass = (r.mask == '0);
      exp_q.push_back(r);

      fault      = f;
      exp_edge   = 4 * (s + 1);
      first_done = -1;
      n_done     = 0;
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      glitch = glitch_mode;
      for (int n = 1; n <= exp_edge + 2; n++) begin
         @(posedge clk); #1;
         if (o_done === 1'b1) begin
            n_done++;
            if (first_done < 0) begin
               first_done = n;
               check_result(tag);
            end
         end
         if (n == exp_edge + 1) begin
            check({tag, "_ab_hold"}, {o_a, o_b}, 2'b11);
            check({tag, "_idle"},    o_busy,     1'b0);
         end
         // Correct res only in the CHECK cycles; garbage everywhere else.
         glitch = glitch_mode && !(((n + 1) % (s + 1) == 0) && n < exp_edge);
         if (extra_start && n == 4) set_start(1'b1);
         if (n == 5)                set_start(1'b0);
      end
      glitch = 1'b0;
      check({tag, "_done_edge"},  first_done, exp_edge);
      check({tag, "_done_count"}, n_done,     1);
      if (first_done < 0) begin
         check({tag, "_result_missing"}, exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      int n_done;
      logic [6:0] tbl [4];
      tbl[0] = 7'b1110100;
      tbl[1] = 7'b0011110;
      tbl[2] = 7'b0011010;
      tbl[3] = 7'b1000011;
      for (int i = 0; i < 4; i++)
         check($sformatf("gate_expect_%0d", i), gate_expect(i[1], i[0]), tbl[i]);

      repeat (3) @(posedge clk);
      #1;
      check("rst_ab",   {a2, b2},  2'b00);
      check("rst_busy", busy2,     1'b0);
      check("rst_done", done2,     1'b0);
      check("rst_pass", pass2,     1'b0);
      check("rst_err",  err2,      7'd0);
      check("rst_fc",   fc2,       3'd0);
      check("rst_ffv",  ffv2,      2'd0);
      check("rst_dut1", {busy1, done1, pass1, err1, fc1, ffv1}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      sel = 0;
      run("good",      2, 0, 1'b0, 1'b0);
      run("not_b",     2, 1, 1'b0, 1'b0);
      run("and_stuck", 2, 2, 1'b0, 1'b0);
      run("glitch",    2, 0, 1'b1, 1'b1);

      // Abort in the second SETTLE cycle of vector 10.
      fault = 1;
      vec_q.push_back(2'b00);
      vec_q.push_back(2'b01);
      vec_q.push_back(2'b10);
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      repeat (7) begin @(posedge clk); #1; end
      check("abort_pre_ab",  {a2, b2}, 2'b10);
      check("abort_pre_err", err2,     7'b0000100);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ab",    {a2, b2}, 2'b00);
      check("abort_busy",  busy2,    1'b0);
      check("abort_done",  done2,    1'b0);
      check("abort_flags", {pass2, err2, fc2, ffv2}, 0);
      n_done = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (done2 === 1'b1) n_done++;
      end
      check("abort_no_done", n_done, 0);
      run("after_abort", 2, 0, 1'b0, 1'b0);

      sel = 1;
      run("b2b_fail", 1, 2, 1'b0, 1'b0);
      run("b2b_good", 1, 0, 1'b0, 1'b0);

      check("vec_q_drained", vec_q.size(), 0);
      check("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
